// File: rtl/sparse_mac_scheduler.sv
// Job-level controller for the sparse-MAC datapath: clear, launch, accumulate, report.
// Optional watchdog on the RUN state is enabled with `define SPARSE_MAC_TIMEOUT_EN.
module sparse_mac_scheduler #(
    parameter int VALUE_W        = 8,
    parameter int ACC_W          = 32,
    parameter int ADDR_W         = 10,
    parameter int LEN_W          = 10,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 mac_clk,
    input  logic                 mac_rst,
    input  logic                 job_valid_i,
    output logic                 job_ready_o,
    input  logic [ID_W-1:0]      job_id_i,
    input  logic [2*ADDR_W-1:0]  job_addr_i,
    input  logic [2*LEN_W-1:0]   job_len_i,
    output logic                 cmp_clear_o,
    output logic                 dec_start_o,
    output logic [2*ADDR_W-1:0]  dec_addr_o,
    output logic [2*LEN_W-1:0]   dec_len_o,
    input  logic                 mac_valid_i,
    input  logic [2*VALUE_W-1:0] mac_data_i,
    input  logic                 mac_finish_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [ID_W-1:0]      res_id_o,
    output logic [ACC_W-1:0]     res_acc_o,
    output logic [LEN_W-1:0]     res_count_o,
    output logic                 res_ovf_o,
    output logic                 res_timeout_o,
    output logic                 busy_o,
    output logic [2:0]           dbg_state_o
);

    // Handshakes: a transfer happens on a rising clock edge where valid and ready are both high;
    // valid-side payload is held stable from assertion until that edge.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    if (ACC_W < 2*VALUE_W || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("sparse_mac_scheduler: need ACC_W >= 2*VALUE_W and TIMEOUT_CYCLES >= 1");
    end

    state_t               state_q;
    logic [ID_W-1:0]      id_q;
    logic [2*ADDR_W-1:0]  addr_q;
    logic [2*LEN_W-1:0]   len_q;
    logic [ACC_W-1:0]     acc_q;
    logic [LEN_W-1:0]     count_q;
    logic                 ovf_q;
    logic                 tmo_flag_q;

    logic signed [VALUE_W-1:0]   l_val, r_val;
    logic signed [2*VALUE_W-1:0] prod;
    logic [ACC_W-1:0]            prod_ext, acc_d;
    logic [LEN_W-1:0]            count_d;
    logic                        ovf_d, tmo_hit;

    assign l_val    = mac_data_i[VALUE_W-1:0];
    assign r_val    = mac_data_i[2*VALUE_W-1:VALUE_W];
    assign prod     = l_val * r_val;
    assign prod_ext = ACC_W'(prod);
    assign acc_d    = acc_q + prod_ext;
    // Signed overflow: operands agree in sign but the sum does not.
    assign ovf_d    = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_d[ACC_W-1] != acc_q[ACC_W-1]);
    assign count_d  = (&count_q) ? count_q : count_q + 1'b1;

`ifdef SPARSE_MAC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;

    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst)             tmo_cnt_q <= '0;
        else if (state_q != S_RUN) tmo_cnt_q <= '0;
        else                      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end

    assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (job_valid_i) begin
                        id_q       <= job_id_i;
                        addr_q     <= job_addr_i;
                        len_q      <= job_len_i;
                        acc_q      <= '0;
                        count_q    <= '0;
                        ovf_q      <= 1'b0;
                        tmo_flag_q <= 1'b0;
                        if (job_len_i[LEN_W-1:0] == '0 || job_len_i[2*LEN_W-1:LEN_W] == '0)
                            state_q <= S_RESULT;
                        else
                            state_q <= S_CLEAR;
                    end
                end
                S_CLEAR:  state_q <= S_LAUNCH;
                S_LAUNCH: state_q <= S_RUN;
                S_RUN: begin
                    if (mac_valid_i) begin
                        acc_q   <= acc_d;
                        ovf_q   <= ovf_q | ovf_d;
                        count_q <= count_d;
                    end
                    if (mac_finish_i) begin
                        state_q <= S_RESULT;
                    end else if (tmo_hit) begin
                        state_q    <= S_RESULT;
                        tmo_flag_q <= 1'b1;
                    end
                end
                S_RESULT: begin
                    if (res_ready_i) begin
                        state_q <= S_IDLE;
                        addr_q  <= '0;
                        len_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign job_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign cmp_clear_o   = (state_q == S_CLEAR);
    assign dec_start_o   = (state_q == S_LAUNCH);
    assign dec_addr_o    = busy_o ? addr_q : '0;
    assign dec_len_o     = busy_o ? len_q : '0;
    assign res_valid_o   = (state_q == S_RESULT);
    assign res_id_o      = id_q;
    assign res_acc_o     = acc_q;
    assign res_count_o   = count_q;
    assign res_ovf_o     = ovf_q;
    assign res_timeout_o = tmo_flag_q;
    assign dbg_state_o   = state_q;

endmodule
